// File: rtl/sensor_conditioner.sv
// Synchronizes, debounces and edge-detects the raw sensor pin, and measures the rise-to-rise period.
// Latency SYNC_STAGES+DEBOUNCE_CYCLES-1 edges from first sampling edge; no backpressure (free-running).
module sensor_conditioner #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int PERIOD_W        = 16,
  parameter int GLITCH_W        = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                sensor,
  output logic                sensor_clean,
  output logic                rise_pulse,
  output logic                fall_pulse,
  output logic [PERIOD_W-1:0] period,
  output logic                period_valid,
  output logic                period_ovf,
  output logic [GLITCH_W-1:0] glitch_cnt
);

  localparam int DCNT_W = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DCNT_W-1:0]   DCNT_MAX = DCNT_W'(DEBOUNCE_CYCLES);
  localparam logic [PERIOD_W-1:0] PCNT_MAX = '1;
  localparam logic [GLITCH_W-1:0] GLITCH_MAX = '1;
  localparam logic [PERIOD_W-1:0] PCNT_ONE = PERIOD_W'(1);

  typedef enum logic [1:0] {STABLE_LOW, QUAL_HIGH, STABLE_HIGH, QUAL_LOW} state_t;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  state_t                 state_q, state_d;
  logic [DCNT_W-1:0]      dcnt_q, dcnt_d, dcnt_inc;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;
  logic                   glitch_inc;
  logic [GLITCH_W-1:0]    glitch_q, glitch_d;
  logic                   armed_q, armed_d;
  logic [PERIOD_W-1:0]    pcnt_q, pcnt_d;
  logic [PERIOD_W-1:0]    period_q, period_d;
  logic                   pv_q, pv_d;
  logic                   ovf_q, ovf_d;
  logic                   s_sync;

  assign s_sync = sync_q[SYNC_STAGES-1];

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], sensor};
  end

  always_comb begin
    state_d    = state_q;
    dcnt_d     = dcnt_q;
    rise_d     = 1'b0;
    fall_d     = 1'b0;
    glitch_inc = 1'b0;
    dcnt_inc   = dcnt_q + 1'b1;
    case (state_q)
      STABLE_LOW: begin
        if (s_sync) begin
          if (DEBOUNCE_CYCLES == 1) begin
            state_d = STABLE_HIGH;
            rise_d  = 1'b1;
            dcnt_d  = '0;
          end else begin
            state_d = QUAL_HIGH;
            dcnt_d  = DCNT_W'(1);
          end
        end
      end
      QUAL_HIGH: begin
        if (!s_sync) begin
          state_d    = STABLE_LOW;
          dcnt_d     = '0;
          glitch_inc = 1'b1;
        end else if (dcnt_inc == DCNT_MAX) begin
          state_d = STABLE_HIGH;
          rise_d  = 1'b1;
          dcnt_d  = '0;
        end else begin
          dcnt_d = dcnt_inc;
        end
      end
      STABLE_HIGH: begin
        if (!s_sync) begin
          if (DEBOUNCE_CYCLES == 1) begin
            state_d = STABLE_LOW;
            fall_d  = 1'b1;
            dcnt_d  = '0;
          end else begin
            state_d = QUAL_LOW;
            dcnt_d  = DCNT_W'(1);
          end
        end
      end
      QUAL_LOW: begin
        if (s_sync) begin
          state_d    = STABLE_HIGH;
          dcnt_d     = '0;
          glitch_inc = 1'b1;
        end else if (dcnt_inc == DCNT_MAX) begin
          state_d = STABLE_LOW;
          fall_d  = 1'b1;
          dcnt_d  = '0;
        end else begin
          dcnt_d = dcnt_inc;
        end
      end
      default: begin
        state_d = STABLE_LOW;
        dcnt_d  = '0;
      end
    endcase
  end

  always_comb begin
    glitch_d = glitch_q;
    if (glitch_inc && (glitch_q != GLITCH_MAX)) begin
      glitch_d = glitch_q + 1'b1;
    end
  end

  // Period bookkeeping keys off the rise event itself so period_valid lines up with rise_pulse.
  always_comb begin
    armed_d  = armed_q;
    pcnt_d   = pcnt_q;
    period_d = period_q;
    ovf_d    = ovf_q;
    pv_d     = 1'b0;
    if (armed_q && (pcnt_q != PCNT_MAX)) begin
      pcnt_d = pcnt_q + 1'b1;
    end
    if (rise_d) begin
      pcnt_d = PCNT_ONE;
      if (!armed_q) begin
        armed_d = 1'b1;
      end else begin
        period_d = pcnt_q;
        ovf_d    = (pcnt_q == PCNT_MAX);
        pv_d     = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q   <= '0;
      state_q  <= STABLE_LOW;
      dcnt_q   <= '0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
      glitch_q <= '0;
      armed_q  <= 1'b0;
      pcnt_q   <= '0;
      period_q <= '0;
      pv_q     <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      sync_q   <= sync_d;
      state_q  <= state_d;
      dcnt_q   <= dcnt_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      glitch_q <= glitch_d;
      armed_q  <= armed_d;
      pcnt_q   <= pcnt_d;
      period_q <= period_d;
      pv_q     <= pv_d;
      ovf_q    <= ovf_d;
    end
  end

  assign sensor_clean = (state_q == STABLE_HIGH) || (state_q == QUAL_LOW);
  assign rise_pulse   = rise_q;
  assign fall_pulse   = fall_q;
  assign period       = period_q;
  assign period_valid = pv_q;
  assign period_ovf   = ovf_q;
  assign glitch_cnt   = glitch_q;

endmodule
